// File: rtl/parity_frame_pkg.sv
// Shared types and line-level constants for the parity frame receiver.
package parity_frame_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Word handshake between the parity frame receiver (master) and its consumer (slave).
interface parity_frame_rx_if #(
  parameter int unsigned DATA_W = 3
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );

endinterface

// File: rtl/parity_frame_fsm.sv
// Frame deserialiser: tracks start/data/parity/stop slots, gathers data bits and running parity.
module parity_frame_fsm
  import parity_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic              frame_done,
  output logic [DATA_W-1:0] word,
  output logic              parity,
  output logic              stop_ok
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par, par_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      par   <= par_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (rx_in == START_BIT) begin
            state_nxt = DATA;
            idx_nxt   = '0;
            par_nxt   = 1'b0;
          end
        end
        DATA: begin
          shreg_nxt[idx] = rx_in;
          par_nxt        = par ^ rx_in;
          if (idx == IDX_LAST) state_nxt = PARITY;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
        PARITY: begin
          par_nxt   = par ^ rx_in;
          state_nxt = STOP;
        end
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Completion is combinational so the top can capture the word on the same edge as the stop sample.
  always_comb begin
    frame_done = bit_en && (state == STOP);
    word       = shreg;
    parity     = par;
    stop_ok    = (rx_in == STOP_BIT);
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Even-parity serial frame receiver with valid/ready output buffer and sticky overrun.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_en,
  input  logic               rx_in,
  parity_frame_rx_if.master  rx_bus,
  output logic               overrun,
  output logic [CNT_W-1:0]   err_cnt
);

  logic              frame_done;
  logic [DATA_W-1:0] word;
  logic              parity;
  logic              stop_ok;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              load;

  parity_frame_fsm #(
    .DATA_W (DATA_W)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .frame_done (frame_done),
    .word       (word),
    .parity     (parity),
    .stop_ok    (stop_ok)
  );

  // Buffer is free when empty or being drained on this very edge.
  assign load = frame_done && (!valid_q || rx_bus.rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= word;
        perr_q  <= parity;
        ferr_q  <= !stop_ok;
        valid_q <= 1'b1;
      end else if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
      end
      if (frame_done && !load) ovr_q <= 1'b1;
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.parity_err = perr_q;
  assign rx_bus.frame_err  = ferr_q;
  assign overrun           = ovr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt_q <= '0;
    else if (load && parity && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
